// File: rtl/noc_inject_arbiter.sv
// Round-robin injection arbiter: one holding slot per requester feeding a single
// router host port with a forced idle gap. Define NOC_ARB_PRIO0_EN to give slot 0 absolute priority.
module noc_inject_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         clr,
  output logic [W-1:0] data,
  output logic         full
);
  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // clr only fires on a full slot, and loads only land on an empty one.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clr) full_d = 1'b0;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;
endmodule

module noc_inject_arbiter #(
  parameter int PACKET_SIZE = 8,
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PACKET_SIZE*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [PACKET_SIZE-1:0]         host_data_in,
  output logic                           host_en,
  output logic [IDW-1:0]                 gnt_id,
  output logic                           busy
);
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [IDW-1:0]                        ptr_q, ptr_d;
  logic [IDW-1:0]                        gnt_q, gnt_d;
  logic                                  host_en_q, host_en_d;
  logic [PACKET_SIZE-1:0]                host_data_q, host_data_d;
  logic [NUM_REQ-1:0][PACKET_SIZE-1:0]   slot_data;
  logic [NUM_REQ-1:0]                    full, clr;
  logic                                  win_vld, win_prio;
  logic [IDW-1:0]                        win_idx, cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    noc_inject_slot #(.W(PACKET_SIZE)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .in_data  (req_data[g*PACKET_SIZE +: PACKET_SIZE]),
      .in_valid (req_valid[g]),
      .clr      (clr[g]),
      .data     (slot_data[g]),
      .full     (full[g])
    );
  end

  assign req_ready = ~full;

  // Rotating search from ptr+1; the first full slot encountered wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_prio = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + 1 + k) % NUM_REQ);
      if (!win_vld && full[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`ifdef NOC_ARB_PRIO0_EN
    if (full[0]) begin
      win_vld  = 1'b1;
      win_idx  = '0;
      win_prio = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= IDW'(NUM_REQ - 1);
      gnt_q       <= '0;
      host_en_q   <= 1'b0;
      host_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      host_en_q   <= host_en_d;
      host_data_q <= host_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (win_vld) state_d = SEND;
      SEND: begin
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered at the grant edge; a priority grant leaves ptr alone.
  always_comb begin
    host_en_d   = 1'b0;
    host_data_d = '0;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    clr         = '0;
    if (state_q == IDLE && win_vld) begin
      host_en_d    = 1'b1;
      host_data_d  = slot_data[win_idx];
      gnt_d        = win_idx;
      clr[win_idx] = 1'b1;
      if (!win_prio) ptr_d = win_idx;
    end
  end

  assign host_en      = host_en_q;
  assign host_data_in = host_data_q;
  assign gnt_id       = gnt_q;
  assign busy         = (state_q != IDLE) || (|full);
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: vector table for single-packet latency,
// a round-robin scoreboard on every grant, and hand sequences for the multi-cycle cases.
module tb_noc_inject_arbiter;
  localparam int P = 8;
  localparam int N = 4;
  localparam int G = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [P*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [P-1:0]   host_data_in;
  logic           host_en;
  logic [1:0]     gnt_id;
  logic           busy;

  noc_inject_arbiter #(.PACKET_SIZE(P), .NUM_REQ(N), .GAP_CYCLES(G)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .host_data_in (host_data_in),
    .host_en      (host_en),
    .gnt_id       (gnt_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per accepted packet, with the edge it was accepted on.
  typedef struct {
    int         id;
    logic [7:0] data;
    int         acc;
  } sb_t;
  sb_t pend[$];
  int  last_id = N - 1;
  int  rise_log[$];
  int  gnt_log[$];
  logic prev_en = 1'b0;

  function automatic int find_cand(input int id);
    for (int j = 0; j < pend.size(); j++)
      if (pend[j].id == id && pend[j].acc < cyc) return j;
    return -1;
  endfunction

  always @(negedge clk) begin
    int exp_id;
    int idx;
    bit prio;
    if (rst) begin
      pend.delete();
      last_id = N - 1;
    end else begin
      if (host_en) begin
        exp_id = -1;
        prio   = 1'b0;
`ifdef NOC_ARB_PRIO0_EN
        if (find_cand(0) >= 0) begin
          exp_id = 0;
          prio   = 1'b1;
        end
`endif
        for (int k = 0; k < N; k++)
          if (exp_id < 0 && find_cand((last_id + 1 + k) % N) >= 0) exp_id = (last_id + 1 + k) % N;
        if (exp_id < 0) begin
          check("unexpected_grant", 32'(host_en), 32'd0);
        end else begin
          idx = find_cand(exp_id);
          check("gnt_id", 32'(gnt_id), 32'(exp_id));
          check("host_data", 32'(host_data_in), 32'(pend[idx].data));
          pend.delete(idx);
          if (!prio) last_id = exp_id;
        end
        check("send_one_cycle", 32'(prev_en), 32'd0);
        rise_log.push_back(cyc);
        gnt_log.push_back(int'(gnt_id));
      end else begin
        check("data_zero_when_idle", 32'(host_data_in), 32'd0);
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) pend.push_back('{i, req_data[i*P +: P], cyc + 1});
    end
    prev_en = host_en;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         id;
    logic [7:0] d;
  } vec_t;
  vec_t tbl[6];

  int base;
  int n1;
  int nw;

  initial begin
    tbl[0] = '{0, 8'h09};
    tbl[1] = '{1, 8'hA5};
    tbl[2] = '{2, 8'hFF};
    tbl[3] = '{3, 8'h80};
    tbl[4] = '{3, 8'h01};
    tbl[5] = '{0, 8'h5A};

    rst = 1'b1; req_valid = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_host_en", 32'(host_en), 32'd0);
    check("rst_host_data", 32'(host_data_in), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single-packet latency: accept at E, host_en after E+1 only, slot free after E+1.
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      req_valid = 4'(1 << tbl[t].id);
      req_data[tbl[t].id*P +: P] = tbl[t].d;
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check("ready_low_after_accept", 32'(req_ready[tbl[t].id]), 32'd0);
      check("no_early_send", 32'(host_en), 32'd0);
      @(negedge clk);
      check("send_latency", 32'(host_en), 32'd1);
      check("ready_again", 32'(req_ready[tbl[t].id]), 32'd1);
      @(negedge clk);
      check("send_drop", 32'(host_en), 32'd0);
      wait_idle("vec_drain");
    end

    // All four slots loaded on one edge.
    do_reset();
    base = rise_log.size();
    @(posedge clk); #1;
    req_valid = 4'hF;
    req_data  = 32'h43322110;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    wait_idle("burst_drain");
    check("burst_count", 32'(rise_log.size() - base), 32'd4);
    if (rise_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) check("burst_order", 32'(gnt_log[base+k]), 32'(k));
      for (int k = 1; k < 4; k++) check("burst_spacing", 32'(rise_log[base+k] - rise_log[base+k-1]), 32'(G + 2));
    end

    // Requester 2 streams continuously while requester 1 sends twice.
    do_reset();
    base = rise_log.size();
    @(posedge clk); #1;
    req_valid = 4'b0110;
    req_data[15:8]  = 8'h1B;
    req_data[23:16] = 8'h2C;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      req_data[23:16] = 8'(8'h30 + k);
      req_valid[1] = (k == 9);
      req_data[15:8] = 8'h1C;
    end
    req_valid = '0;
    @(negedge clk);
    wait_idle("fair_drain");
    n1 = 0;
    for (int k = base; k < gnt_log.size(); k++) if (gnt_log[k] == 1) n1++;
    check("fair_req1_grants", 32'(n1), 32'd2);
    if (gnt_log.size() > base) check("fair_first_grant", 32'(gnt_log[base]), 32'd1);

    // Reset in the middle of SEND with slots 1 and 3 full.
    do_reset();
    @(posedge clk); #1;
    req_valid = 4'b1010;
    req_data[15:8]  = 8'h77;
    req_data[31:24] = 8'h99;
    @(posedge clk); #1 req_valid = '0;
    nw = 0;
    @(negedge clk);
    while (!host_en && nw < 10) begin
      @(negedge clk);
      nw++;
    end
    check("rstsend_saw_send", 32'(host_en), 32'd1);
    rst = 1'b1;
    #1;
    check("rstsend_host_en", 32'(host_en), 32'd0);
    check("rstsend_host_data", 32'(host_data_in), 32'd0);
    check("rstsend_req_ready", 32'(req_ready), 32'hF);
    check("rstsend_gnt_id", 32'(gnt_id), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    base = rise_log.size();
    repeat (12) @(negedge clk);
    check("rstsend_no_inject", 32'(rise_log.size() - base), 32'd0);

    // Slots 0 and 2 held full, slot 0 refilled whenever it empties.
    do_reset();
    base = rise_log.size();
    @(posedge clk); #1;
    req_valid = 4'b0101;
    for (int k = 0; k < 20; k++) begin
      req_data[7:0]   = 8'(8'h50 + k);
      req_data[23:16] = 8'(8'hA0 + k);
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    wait_idle("prio_drain");
    if (gnt_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) begin
`ifdef NOC_ARB_PRIO0_EN
        check("prio_grant", 32'(gnt_log[base+k]), 32'd0);
`else
        check("rr_grant", 32'(gnt_log[base+k]), 32'((k % 2) * 2));
`endif
      end
    end else begin
      check("prio_grant_count", 32'(gnt_log.size() - base), 32'd4);
    end

    check("scoreboard_drained", 32'(pend.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
